// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex digit scanner: cycles NDIGITS digits with guard (all-off) cycles,
// active-low registered digit enables, leading-zero blanking and frame-aligned double-buffered updates.
module hex_display_scanner #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   blank_lz,
  output logic [3:0]             d,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame,
  output logic                   upd_done
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - GUARD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_SHOW
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_cnt;
  logic [4*NDIGITS-1:0]  r_disp;
  logic [4*NDIGITS-1:0]  r_pend;
  logic                  r_pending;

  logic [NDIGITS-1:0]    w_blank;
  logic [NDIGITS-1:0]    w_an_show;
  logic [3:0]            w_d;
  logic                  w_show_end;
  logic                  w_wrap;
  logic                  w_xfer;

  // A digit above 0 is blanked when it and every more significant digit are zero.
  always_comb begin
    w_blank = '0;
    for (int k = 1; k < NDIGITS; k++) begin
      w_blank[k] = blank_lz && ((r_disp >> (4 * k)) == '0);
    end
  end

  always_comb begin
    w_an_show = '1;
    w_d       = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_an_show[k] = w_blank[k];
        w_d          = r_disp[4*k +: 4];
      end
    end
  end

  assign d          = w_d;
  assign w_show_end = (r_state == S_SHOW) && (r_cnt == SHOW_LAST);
  assign w_wrap     = en && w_show_end && (r_idx == IDX_LAST);
  assign w_xfer     = r_pending && ((r_state == S_OFF) || w_wrap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_OFF;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_disp    <= '0;
      r_pend    <= '0;
      r_pending <= 1'b0;
      an        <= '1;
      frame     <= 1'b0;
      upd_done  <= 1'b0;
    end else begin
      frame    <= 1'b0;
      upd_done <= 1'b0;

      if (w_xfer) begin
        r_disp    <= r_pend;
        r_pending <= 1'b0;
        upd_done  <= 1'b1;
      end
      // A load on the transfer edge re-arms pending with the new value.
      if (load) begin
        r_pend    <= value;
        r_pending <= 1'b1;
      end

      if (!en) begin
        r_state <= S_OFF;
        r_idx   <= '0;
        r_cnt   <= '0;
        an      <= '1;
      end else begin
        case (r_state)
          S_OFF: begin
            r_state <= S_GUARD;
            r_idx   <= '0;
            r_cnt   <= '0;
            frame   <= 1'b1;
            an      <= '1;
          end
          S_GUARD: begin
            if (r_cnt == GUARD_LAST) begin
              r_state <= S_SHOW;
              r_cnt   <= '0;
              an      <= w_an_show;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              an    <= '1;
            end
          end
          S_SHOW: begin
            if (r_cnt == SHOW_LAST) begin
              r_state <= S_GUARD;
              r_cnt   <= '0;
              an      <= '1;
              if (r_idx == IDX_LAST) begin
                r_idx <= '0;
                frame <= 1'b1;
              end else begin
                r_idx <= r_idx + IDX_ONE;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              an    <= w_an_show;
            end
          end
          default: begin
            r_state <= S_OFF;
            r_idx   <= '0;
            r_cnt   <= '0;
            an      <= '1;
          end
        endcase
      end
    end
  end

endmodule
